inst_r_decoder: RTL and testbench
=================================

INST_R_DECODER -- requirements
Module: inst_r_decoder

Interface
REQ-001 SHALL have parameter SUPPORT_M, default 0, meaning 1 enables RV32M R-type decode (funct7=0000001).
REQ-002 SHALL have port clk, input, 1 bit, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, instruction_word is valid this cycle.
REQ-005 SHALL have port instruction_word, input, 32 bits, raw RV32 instruction.
REQ-006 SHALL have port rs2, output, 5 bits, source register 2 = instruction_word[24:20].
REQ-007 SHALL have port rs1, output, 5 bits, source register 1 = instruction_word[19:15].
REQ-008 SHALL have port rd, output, 5 bits, destination register = instruction_word[11:7].
REQ-009 SHALL have port funct3, output, 3 bits = instruction_word[14:12].
REQ-010 SHALL have port funct7, output, 7 bits = instruction_word[31:25].
REQ-011 SHALL have port alu_op, output, 5 bits, decoded operation code (REQ-017).
REQ-012 SHALL have port out_valid, output, 1 bit, outputs hold a decode result.
REQ-013 SHALL have port illegal, output, 1 bit, decoded word is not a supported R-type.
REQ-014 SHALL have port reg_write, output, 1 bit, legal R-type with rd != 0.

Function
REQ-015 SHALL register all outputs; latency exactly 1 cycle from in_valid sample to out_valid.
REQ-016 SHALL, when in_valid=1, capture the rs2/rs1/rd/funct3/funct7 fields unconditionally, whatever the opcode.
REQ-017 SHALL encode alu_op: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, MUL=10, MULH=11, MULHSU=12, MULHU=13, DIV=14, DIVU=15, REM=16, REMU=17.
REQ-018 SHALL decode funct7=0000000 with funct3 000..111 as ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
REQ-019 SHALL decode funct7=0100000 with funct3=000 as SUB and funct3=101 as SRA; other funct3 values with this funct7 SHALL be illegal.
REQ-020 SHALL, when SUPPORT_M=1, decode funct7=0000001 with funct3 000..111 as MUL..REMU in order; when SUPPORT_M=0, funct7=0000001 SHALL be illegal.
REQ-021 SHALL flag illegal=1 when opcode [6:0] != 0110011 or the funct7/funct3 combination is unsupported; in that case alu_op=0 and reg_write=0.
REQ-022 SHALL set reg_write=1 only for legal decodes with rd != 0.
REQ-023 SHALL, when in_valid=0, drive out_valid=0 next cycle and hold all other outputs at their previous values.
REQ-024 SHALL accept back-to-back valid instructions every cycle with no bubbles.

Reset
REQ-025 SHALL, while rst=1 at a rising edge, clear out_valid, illegal, reg_write, alu_op, rs2, rs1, rd, funct3 and funct7 to 0.
REQ-026 SHALL give rst priority over in_valid in the same cycle; the instruction is dropped.
REQ-027 SHALL produce a valid decode on the first edge with rst=0 and in_valid=1.

Verification
REQ-028 0x004A82B3 (add) -> next cycle: rs2=4, rs1=21, rd=5, funct3=0, funct7=0, alu_op=0, illegal=0, reg_write=1, out_valid=1.
REQ-029 0x405A8333 (sub) -> rs2=5, rs1=21, rd=6, funct7=0x20, alu_op=1, illegal=0, reg_write=1.
REQ-030 0x004A12B3 (sll) -> rs2=4, rs1=20, rd=5, funct3=1, alu_op=2, illegal=0, reg_write=1.
REQ-031 0x00000013 (addi, non-R opcode) -> illegal=1, alu_op=0, reg_write=0, out_valid=1; 0x40001033 (funct7=0x20, funct3=1) -> illegal=1.
REQ-032 0x02A282B3 (mul) with SUPPORT_M=0 -> illegal=1; with SUPPORT_M=1 -> alu_op=10, illegal=0. 0x00000033 (add, rd=0) -> reg_write=0, illegal=0.
REQ-033 rst=1 with in_valid=1 mid-stream -> all outputs 0 next cycle; in_valid dropped to 0 -> out_valid=0 and the fields hold their previous values.

Source files
------------

// File: rtl/inst_r_decoder.sv
// ---------------------------------------------------------------------------
// inst_r_decoder
//
// Single-stage RV32 R-type instruction decoder. Every accepted instruction
// word is split into its register/function fields and classified into an
// ALU operation code. All outputs are registered, so a decode appears
// exactly one cycle after the word is presented with in_valid=1.
// A new word can be accepted every cycle.
//
// Parameters
//   SUPPORT_M         1 = decode RV32M (funct7=0000001), 0 = treat as illegal
//
// Ports
//   clk               sole clock, rising-edge
//   rst               synchronous active-high reset
//   in_valid          instruction_word is valid this cycle
//   instruction_word  raw 32-bit RV32 instruction
//   rs2, rs1, rd      register fields captured from the word
//   funct3, funct7    function fields captured from the word
//   alu_op            decoded operation (0 when illegal)
//   out_valid         outputs hold a fresh decode result this cycle
//   illegal           captured word is not a supported R-type
//   reg_write         legal decode that targets a register other than x0
// ---------------------------------------------------------------------------
module inst_r_decoder #(
    parameter int unsigned SUPPORT_M = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instruction_word,
    output logic [4:0]  rs2,
    output logic [4:0]  rs1,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  alu_op,
    output logic        out_valid,
    output logic        illegal,
    output logic        reg_write
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_MUL  = 5'd10;

    // Field slices of the incoming word.
    logic [6:0] opcode_w;
    logic [4:0] rd_w;
    logic [2:0] funct3_w;
    logic [4:0] rs1_w;
    logic [4:0] rs2_w;
    logic [6:0] funct7_w;

    assign opcode_w = instruction_word[6:0];
    assign rd_w     = instruction_word[11:7];
    assign funct3_w = instruction_word[14:12];
    assign rs1_w    = instruction_word[19:15];
    assign rs2_w    = instruction_word[24:20];
    assign funct7_w = instruction_word[31:25];

    logic [4:0] alu_op_d;
    logic       illegal_d;
    logic       reg_write_d;

    // Combinational classification of the incoming word.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        alu_op_d  = ALU_ADD;
        illegal_d = 1'b0;

        if (opcode_w != OPC_OP) begin
            illegal_d = 1'b1;
        end else begin
            case (funct7_w)
                F7_BASE: begin
                    case (funct3_w)
                        3'd0:    alu_op_d = ALU_ADD;
                        3'd1:    alu_op_d = ALU_SLL;
                        3'd2:    alu_op_d = ALU_SLT;
                        3'd3:    alu_op_d = ALU_SLTU;
                        3'd4:    alu_op_d = ALU_XOR;
                        3'd5:    alu_op_d = ALU_SRL;
                        3'd6:    alu_op_d = ALU_OR;
                        default: alu_op_d = ALU_AND;
                    endcase
                end
                F7_ALT: begin
                    if (funct3_w == 3'd0) begin
                        alu_op_d = ALU_SUB;
                    end else if (funct3_w == 3'd5) begin
                        alu_op_d = ALU_SRA;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                F7_MULDIV: begin
                    // MUL..REMU occupy consecutive codes in funct3 order.
                    if (SUPPORT_M != 0) begin
                        alu_op_d = ALU_MUL + {2'b00, funct3_w};
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                default: illegal_d = 1'b1;
            endcase
        end

        reg_write_d = !illegal_d && (rd_w != 5'd0);
    end

    logic [4:0] rs2_q;
    logic [4:0] rs1_q;
    logic [4:0] rd_q;
    logic [2:0] funct3_q;
    logic [6:0] funct7_q;
    logic [4:0] alu_op_q;
    logic       out_valid_q;
    logic       illegal_q;
    logic       reg_write_q;

    // Output register stage. When in_valid is low only out_valid drops;
    // the rest of the stage holds the last decode.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            rs2_q       <= '0;
            rs1_q       <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            alu_op_q    <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (in_valid) begin
            rs2_q       <= rs2_w;
            rs1_q       <= rs1_w;
            rd_q        <= rd_w;
            funct3_q    <= funct3_w;
            funct7_q    <= funct7_w;
            alu_op_q    <= alu_op_d;
            out_valid_q <= 1'b1;
            illegal_q   <= illegal_d;
            reg_write_q <= reg_write_d;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign rs2       = rs2_q;
    assign rs1       = rs1_q;
    assign rd        = rd_q;
    assign funct3    = funct3_q;
    assign funct7    = funct7_q;
    assign alu_op    = alu_op_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign reg_write = reg_write_q;

endmodule

// File: tb/tb_inst_r_decoder.sv
// ---------------------------------------------------------------------------
// tb_inst_r_decoder
//
// Directed testbench for inst_r_decoder. Two instances share the same
// stimulus: one without and one with RV32M support. A table of instruction
// words with hand-computed expected fields/opcodes is streamed back-to-back,
// followed by hand-written sequences for hold, mid-stream reset and the
// first decode after reset.
// ---------------------------------------------------------------------------
module tb_inst_r_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instruction_word;

    logic [4:0] rs2_0, rs1_0, rd_0, alu_op_0;
    logic [2:0] funct3_0;
    logic [6:0] funct7_0;
    logic       out_valid_0, illegal_0, reg_write_0;

    logic [4:0] rs2_1, rs1_1, rd_1, alu_op_1;
    logic [2:0] funct3_1;
    logic [6:0] funct7_1;
    logic       out_valid_1, illegal_1, reg_write_1;

    inst_r_decoder #(.SUPPORT_M(0)) dut_m0 (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .instruction_word (instruction_word),
        .rs2              (rs2_0),
        .rs1              (rs1_0),
        .rd               (rd_0),
        .funct3           (funct3_0),
        .funct7           (funct7_0),
        .alu_op           (alu_op_0),
        .out_valid        (out_valid_0),
        .illegal          (illegal_0),
        .reg_write        (reg_write_0)
    );

    inst_r_decoder #(.SUPPORT_M(1)) dut_m1 (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .instruction_word (instruction_word),
        .rs2              (rs2_1),
        .rs1              (rs1_1),
        .rd               (rd_1),
        .funct3           (funct3_1),
        .funct7           (funct7_1),
        .alu_op           (alu_op_1),
        .out_valid        (out_valid_1),
        .illegal          (illegal_1),
        .reg_write        (reg_write_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  alu0;   // expected alu_op without M
        logic        ill0;   // expected illegal without M
        logic [4:0]  alu1;   // expected alu_op with M
        logic        ill1;   // expected illegal with M
    } vec_t;

    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t vr(input logic [31:0] instr,
                                input logic [4:0] rs2, input logic [4:0] rs1,
                                input logic [4:0] rd, input logic [2:0] f3,
                                input logic [6:0] f7,
                                input logic [4:0] alu0, input logic ill0,
                                input logic [4:0] alu1, input logic ill1);
        vec_t v;
        v.instr = instr; v.rs2 = rs2; v.rs1 = rs1; v.rd = rd;
        v.f3 = f3; v.f7 = f7;
        v.alu0 = alu0; v.ill0 = ill0; v.alu1 = alu1; v.ill1 = ill1;
        return v;
    endfunction

    // Entry whose word is assembled from its own fields.
    function automatic vec_t vb(input logic [6:0] f7, input logic [4:0] rs2,
                                input logic [4:0] rs1, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [6:0] opc,
                                input logic [4:0] alu0, input logic ill0,
                                input logic [4:0] alu1, input logic ill1);
        return vr({f7, rs2, rs1, f3, rd, opc}, rs2, rs1, rd, f3, f7,
                  alu0, ill0, alu1, ill1);
    endfunction

    // Every output of both instances must be zero.
    task automatic check_zero(input string tag);
        check({tag, " m0 out_valid"}, 32'(out_valid_0), 0);
        check({tag, " m0 illegal"},   32'(illegal_0),   0);
        check({tag, " m0 reg_write"}, 32'(reg_write_0), 0);
        check({tag, " m0 alu_op"},    32'(alu_op_0),    0);
        check({tag, " m0 rs2"},       32'(rs2_0),       0);
        check({tag, " m0 rs1"},       32'(rs1_0),       0);
        check({tag, " m0 rd"},        32'(rd_0),        0);
        check({tag, " m0 funct3"},    32'(funct3_0),    0);
        check({tag, " m0 funct7"},    32'(funct7_0),    0);
        check({tag, " m1 out_valid"}, 32'(out_valid_1), 0);
        check({tag, " m1 alu_op"},    32'(alu_op_1),    0);
        check({tag, " m1 reg_write"}, 32'(reg_write_1), 0);
        check({tag, " m1 rd"},        32'(rd_1),        0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        localparam logic [6:0] OP  = 7'b0110011;
        localparam logic [6:0] Z7  = 7'h00;
        localparam logic [6:0] A7  = 7'h20;
        localparam logic [6:0] M7  = 7'h01;

        // Spec words, fields decoded by hand.
        vecs.push_back(vr(32'h004A82B3, 4, 21, 5, 0, Z7,  0, 0,  0, 0)); // add
        vecs.push_back(vr(32'h405A8333, 5, 21, 6, 0, A7,  1, 0,  1, 0)); // sub
        vecs.push_back(vr(32'h004A12B3, 4, 20, 5, 1, Z7,  2, 0,  2, 0)); // sll
        vecs.push_back(vr(32'h00000013, 0,  0, 0, 0, Z7,  0, 1,  0, 1)); // addi
        vecs.push_back(vr(32'h40001033, 0,  0, 0, 1, A7,  0, 1,  0, 1)); // alt f3=1
        vecs.push_back(vr(32'h02A282B3, 10, 5, 5, 0, M7,  0, 1, 10, 0)); // mul
        vecs.push_back(vr(32'h00000033, 0,  0, 0, 0, Z7,  0, 0,  0, 0)); // add x0
        // Remaining base ops.
        vecs.push_back(vb(Z7, 31, 1, 2, 31, OP,  3, 0,  3, 0));          // slt
        vecs.push_back(vb(Z7,  2, 3, 3,  1, OP,  4, 0,  4, 0));          // sltu
        vecs.push_back(vb(Z7,  7, 8, 4,  9, OP,  5, 0,  5, 0));          // xor
        vecs.push_back(vb(Z7, 10, 11, 5, 12, OP, 6, 0,  6, 0));          // srl
        vecs.push_back(vb(Z7, 13, 14, 6, 15, OP, 8, 0,  8, 0));          // or
        vecs.push_back(vb(Z7, 16, 17, 7, 18, OP, 9, 0,  9, 0));          // and
        vecs.push_back(vb(A7, 19, 20, 5, 21, OP, 7, 0,  7, 0));          // sra
        vecs.push_back(vb(A7,  1,  2, 2,  3, OP, 0, 1,  0, 1));          // alt f3=2
        vecs.push_back(vb(A7,  4,  5, 7,  6, OP, 0, 1,  0, 1));          // alt f3=7
        // M extension rows.
        vecs.push_back(vb(M7, 1, 2, 1, 3, OP,  0, 1, 11, 0));            // mulh
        vecs.push_back(vb(M7, 4, 5, 2, 6, OP,  0, 1, 12, 0));            // mulhsu
        vecs.push_back(vb(M7, 7, 8, 3, 9, OP,  0, 1, 13, 0));            // mulhu
        vecs.push_back(vb(M7, 10, 11, 4, 12, OP, 0, 1, 14, 0));          // div
        vecs.push_back(vb(M7, 13, 14, 5, 15, OP, 0, 1, 15, 0));          // divu
        vecs.push_back(vb(M7, 16, 17, 6, 18, OP, 0, 1, 16, 0));          // rem
        vecs.push_back(vb(M7, 19, 20, 7, 21, OP, 0, 1, 17, 0));          // remu
        vecs.push_back(vb(M7, 22, 23, 0,  0, OP, 0, 1, 10, 0));          // mul x0
        // Unsupported funct7 and wrong opcode with valid-looking fields.
        vecs.push_back(vb(7'h7F, 3, 4, 0, 5, OP,        0, 1, 0, 1));
        vecs.push_back(vb(Z7,    3, 4, 0, 5, 7'h3B,     0, 1, 0, 1));

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; instruction_word = '0;
        step();
        step();
        check_zero("reset");

        // Back-to-back table stream.
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            logic  rw0, rw1;
            t = $sformatf("v%0d", i);
            rw0 = !vecs[i].ill0 && (vecs[i].rd != 0);
            rw1 = !vecs[i].ill1 && (vecs[i].rd != 0);
            in_valid = 1'b1;
            instruction_word = vecs[i].instr;
            step();
            check({t, " out_valid"},    32'(out_valid_0), 1);
            check({t, " out_valid m1"}, 32'(out_valid_1), 1);
            check({t, " rs2"},          32'(rs2_0),    32'(vecs[i].rs2));
            check({t, " rs1"},          32'(rs1_0),    32'(vecs[i].rs1));
            check({t, " rd"},           32'(rd_0),     32'(vecs[i].rd));
            check({t, " funct3"},       32'(funct3_0), 32'(vecs[i].f3));
            check({t, " funct7"},       32'(funct7_0), 32'(vecs[i].f7));
            check({t, " rd m1"},        32'(rd_1),     32'(vecs[i].rd));
            check({t, " alu_op m0"},    32'(alu_op_0),    32'(vecs[i].alu0));
            check({t, " illegal m0"},   32'(illegal_0),   32'(vecs[i].ill0));
            check({t, " reg_write m0"}, 32'(reg_write_0), 32'(rw0));
            check({t, " alu_op m1"},    32'(alu_op_1),    32'(vecs[i].alu1));
            check({t, " illegal m1"},   32'(illegal_1),   32'(vecs[i].ill1));
            check({t, " reg_write m1"}, 32'(reg_write_1), 32'(rw1));
        end

        // Hold: decode sub, then drop in_valid while presenting another word.
        instruction_word = 32'h405A8333;
        step();
        in_valid = 1'b0;
        instruction_word = 32'h004A12B3;
        step();
        check("hold out_valid",    32'(out_valid_0), 0);
        check("hold out_valid m1", 32'(out_valid_1), 0);
        check("hold rs2",          32'(rs2_0),       5);
        check("hold rs1",          32'(rs1_0),       21);
        check("hold rd",           32'(rd_0),        6);
        check("hold funct3",       32'(funct3_0),    0);
        check("hold funct7",       32'(funct7_0),    32'h20);
        check("hold alu_op",       32'(alu_op_0),    1);
        check("hold illegal",      32'(illegal_0),   0);
        check("hold reg_write",    32'(reg_write_0), 1);
        step();
        check("hold2 out_valid",   32'(out_valid_0), 0);
        check("hold2 rd",          32'(rd_0),        6);

        // Mid-stream: one valid word, then reset with in_valid still high.
        in_valid = 1'b1;
        instruction_word = 32'h004A12B3;
        step();
        check("pre-rst alu_op", 32'(alu_op_0), 2);
        rst = 1'b1;
        instruction_word = 32'h02A282B3;
        step();
        check_zero("rst-mid");

        // First edge after reset release decodes immediately.
        rst = 1'b0;
        step();
        check("post-rst out_valid",  32'(out_valid_1), 1);
        check("post-rst alu_op m1",  32'(alu_op_1),    10);
        check("post-rst illegal m1", 32'(illegal_1),   0);
        check("post-rst reg_write",  32'(reg_write_1), 1);
        check("post-rst rd",         32'(rd_1),        5);
        check("post-rst rs2",        32'(rs2_1),       10);
        check("post-rst illegal m0", 32'(illegal_0),   1);
        check("post-rst alu_op m0",  32'(alu_op_0),    0);
        in_valid = 1'b0;
        step();
        check("tail out_valid", 32'(out_valid_1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
